// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery result packer.
// Frame geometry defaults to a 4096-bit result carried as 128 x 32-bit blocks.
package mont_pkg;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_REGISTER_SIZE = 32;
  localparam int DEF_BITS_IN_NUM   = 4096;
  localparam int BLOCKS_PER_FRAME  = DEF_BITS_IN_NUM / DEF_REGISTER_SIZE;
  localparam int BYTES_PER_BLOCK   = DEF_REGISTER_SIZE / 8;
  localparam int FRAME_IDX_W       = width_of(BLOCKS_PER_FRAME);
  localparam int FRAME_ADDR_W      = FRAME_IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/pingpong_buffer.sv
// Two-bank simple dual-port RAM addressed as {bank, idx}; registered read,
// no reset on storage or read data so it maps onto block RAM.
module pingpong_buffer
  import mont_pkg::*;
#(
  parameter int DATA_W = DEF_REGISTER_SIZE,
  parameter int ADDR_W = FRAME_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // one-cycle registered read port
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mont_result_packer.sv
// Captures finished accumulator results into a ping-pong buffer and replays
// each one as a valid/ready byte stream, least-significant byte first.
module mont_result_packer
  import mont_pkg::*;
#(
  parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int BITS_IN_NUM   = DEF_BITS_IN_NUM
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  output logic [7:0]               byte_out,
  output logic                     byte_valid_out,
  input  logic                     byte_ready_in,
  output logic                     last_out,
  output logic [15:0]              frame_count_out,
  output logic                     overflow_out,
  output logic                     busy_out
);

  localparam int BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int BPB    = REGISTER_SIZE / 8;
  localparam int IDX_W  = width_of(BLOCKS);
  localparam int BSEL_W = width_of(BPB);
  localparam int AW     = IDX_W + 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BLOCKS - 1);
  localparam logic [BSEL_W-1:0] BSEL_LAST = BSEL_W'(BPB - 1);

  logic [1:0]         full;
  logic               wr_bank;
  logic [IDX_W-1:0]   wr_idx;
  logic               drop;
  logic               overflow;
  rd_state_t          state;
  rd_state_t          state_nxt;
  logic               rd_bank;
  logic [IDX_W-1:0]   rd_idx;
  logic [BSEL_W-1:0]  byte_sel;
  logic [15:0]        frame_count;

  logic                     hs, last_byte, last_blk, frame_done;
  logic                     wr_first, wr_end, wr_full_seen, drop_now, mem_we;
  logic [1:0]               clr_mask, set_mask;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;
  logic [REGISTER_SIZE-1:0] word_q;

  assign hs         = (state == SEND) && byte_ready_in;
  assign last_byte  = (byte_sel == BSEL_LAST);
  assign last_blk   = (rd_idx == IDX_LAST);
  assign frame_done = hs && last_byte && last_blk;

  // A bank being released this cycle counts as free to the writer.
  assign wr_first     = valid_in && (wr_idx == IDX_W'(0));
  assign wr_end       = valid_in && (wr_idx == IDX_LAST);
  assign wr_full_seen = full[wr_bank] && !(frame_done && (rd_bank == wr_bank));
  assign drop_now     = drop || (wr_first && wr_full_seen);
  assign mem_we       = valid_in && !drop_now;

  assign clr_mask = frame_done ? (2'b01 << rd_bank) : 2'b00;
  assign set_mask = (wr_end && !drop_now) ? (2'b01 << wr_bank) : 2'b00;

  pingpong_buffer #(
    .DATA_W (REGISTER_SIZE),
    .ADDR_W (AW)
  ) u_buf (
    .clk     (clk_in),
    .wr_en   (mem_we),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (word_q)
  );

  // write pointer, per-frame drop flag and sticky overflow
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_bank  <= 1'b0;
      wr_idx   <= IDX_W'(0);
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else if (valid_in) begin
      if (wr_end) begin
        wr_idx <= IDX_W'(0);
        drop   <= 1'b0;
        if (!drop_now) begin
          wr_bank <= ~wr_bank;
        end
      end else begin
        wr_idx <= wr_idx + IDX_W'(1);
        drop   <= drop_now;
      end
      if (wr_first && wr_full_seen) begin
        overflow <= 1'b1;
      end
    end
  end

  // bank occupancy flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~clr_mask) | set_mask;
    end
  end

  // read FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next block is read on the final byte's handshake so it lands with no bubble.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = {rd_bank, rd_idx + IDX_W'(1)};
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = FETCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FETCH: begin
        rd_en     = 1'b1;
        rd_addr   = {rd_bank, IDX_W'(0)};
        state_nxt = SEND;
      end
      SEND: begin
        if (frame_done) begin
          state_nxt = full[~rd_bank] ? FETCH : IDLE;
        end else if (hs && last_byte) begin
          rd_en     = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = SEND;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // read pointers and sent-frame counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_bank     <= 1'b0;
      rd_idx      <= IDX_W'(0);
      byte_sel    <= BSEL_W'(0);
      frame_count <= 16'd0;
    end else if (hs) begin
      if (last_byte) begin
        byte_sel <= BSEL_W'(0);
        if (last_blk) begin
          rd_idx      <= IDX_W'(0);
          rd_bank     <= ~rd_bank;
          frame_count <= frame_count + 16'd1;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end else begin
        byte_sel <= byte_sel + BSEL_W'(1);
      end
    end
  end

  assign byte_valid_out  = (state == SEND);
  assign byte_out        = byte_valid_out ? 8'(word_q >> {byte_sel, 3'b000}) : 8'h00;
  assign last_out        = byte_valid_out && last_byte && last_blk;
  assign frame_count_out = frame_count;
  assign overflow_out    = overflow;
  assign busy_out        = (|full) || (wr_idx != IDX_W'(0));

endmodule

// File: tb/tb_mont_result_packer.sv
// Scenario bench for mont_result_packer: frames of random or patterned blocks,
// expected bytes derived from each frame as a little-endian number.
module tb_mont_result_packer;
  import mont_pkg::*;

  localparam int FB = BLOCKS_PER_FRAME * BYTES_PER_BLOCK;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        byte_ready_in = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        last_out;
  logic [15:0] frame_count_out;
  logic        overflow_out;
  logic        busy_out;

  mont_result_packer dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .byte_out        (byte_out),
    .byte_valid_out  (byte_valid_out),
    .byte_ready_in   (byte_ready_in),
    .last_out        (last_out),
    .frame_count_out (frame_count_out),
    .overflow_out    (overflow_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  logic [31:0] fr [4][BLOCKS_PER_FRAME];
  logic [7:0]  got_b [$];
  logic        got_l [$];
  int          got_c [$];
  int          stab_err;
  int          exp_ids [$];

  function automatic logic [7:0] model_byte(input int f, input int k);
    logic [31:0] w;
    w = fr[f][k / BYTES_PER_BLOCK];
    return w[8 * (k % BYTES_PER_BLOCK) +: 8];
  endfunction

  function automatic int stream_bad();
    int bad = 0;
    for (int k = 0; k < got_b.size(); k++) begin
      int fi = k / FB;
      int off = k % FB;
      if (fi >= exp_ids.size()) bad++;
      else begin
        if (got_b[k] !== model_byte(exp_ids[fi], off)) bad++;
        if (got_l[k] !== (off == FB - 1)) bad++;
      end
    end
    return bad;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill(input int f, input bit fixed);
    for (int i = 0; i < BLOCKS_PER_FRAME; i++)
      fr[f][i] = fixed ? (32'hA500_0000 + 32'(i)) : $urandom;
  endtask

  task automatic send_blocks(input int f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      valid_in = 1'b1;
      data_in  = fr[f][i];
      step();
    end
    valid_in = 1'b0;
    data_in  = 32'd0;
  endtask

  // Sink: accepts up to nbytes with ready high pct% of cycles, logs stalls that move.
  task automatic sink_run(input int nbytes, input int pct, input int budget);
    logic hold = 1'b0;
    logic [7:0] pb = 8'd0;
    logic pl = 1'b0;
    int n = 0;
    got_b.delete(); got_l.delete(); got_c.delete();
    stab_err = 0;
    for (int c = 0; c < budget && n < nbytes; c++) begin
      if (byte_valid_out && hold && (byte_out !== pb || last_out !== pl)) stab_err++;
      byte_ready_in = ($urandom_range(99, 0) < pct);
      if (byte_valid_out && byte_ready_in) begin
        got_b.push_back(byte_out);
        got_l.push_back(last_out);
        got_c.push_back(cyc);
        n++;
        hold = 1'b0;
      end else begin
        hold = byte_valid_out;
        pb = byte_out;
        pl = last_out;
      end
      step();
    end
    byte_ready_in = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    byte_ready_in = 1'b0;
    repeat (3) step();
    rst_n_in = 1'b1;
    step();
    exp_frames = 0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) step();
    checks++;
    if ({byte_out, byte_valid_out, last_out} !== 10'd0) begin
      errors++;
      $display("FAIL reset_stream: got %h required 0", {byte_out, byte_valid_out, last_out});
    end
    checks++;
    if ({frame_count_out, overflow_out, busy_out} !== 18'd0) begin
      errors++;
      $display("FAIL reset_status: got %h required 0", {frame_count_out, overflow_out, busy_out});
    end
    rst_n_in = 1'b1;
    step();
    checks++;
    if ({byte_valid_out, busy_out} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got %b required 00", {byte_valid_out, busy_out});
    end
  endtask

  task automatic test_single_frame();
    logic [2:0] v;
    int span;
    fill(0, 1'b1);
    exp_ids = {0};
    send_blocks(0, 0, 0);
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL busy_writing: got %b required 1", busy_out);
    end
    send_blocks(0, 1, BLOCKS_PER_FRAME - 1);
    v[2] = byte_valid_out; step();
    v[1] = byte_valid_out; step();
    v[0] = byte_valid_out;
    checks++;
    if (v !== 3'b001) begin
      errors++;
      $display("FAIL start_latency: got %b required 001", v);
    end
    sink_run(FB, 100, FB + 50);
    exp_frames++;
    checks++;
    if (got_b.size() !== FB) begin
      errors++;
      $display("FAIL single_count: got %0d required %0d", got_b.size(), FB);
    end
    checks++;
    if (stream_bad() !== 0) begin
      errors++;
      $display("FAIL single_bytes: got %0d bad required 0", stream_bad());
    end
    span = (got_c.size() == FB) ? (got_c[FB-1] - got_c[0]) : -1;
    checks++;
    if (span !== FB - 1) begin
      errors++;
      $display("FAIL single_continuous: got %0d required %0d", span, FB - 1);
    end
    checks++;
    if (frame_count_out !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL single_frames: got %0d required %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    fill(1, 1'b0);
    exp_ids = {1};
    fork
      send_blocks(1, 0, BLOCKS_PER_FRAME - 1);
      sink_run(FB, 30, 8000);
    join
    exp_frames++;
    checks++;
    if (got_b.size() !== FB) begin
      errors++;
      $display("FAIL bp_count: got %0d required %0d", got_b.size(), FB);
    end
    checks++;
    if (stream_bad() !== 0) begin
      errors++;
      $display("FAIL bp_bytes: got %0d bad required 0", stream_bad());
    end
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d changes required 0", stab_err);
    end
    checks++;
    if (frame_count_out !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL bp_frames: got %0d required %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    fill(0, 1'b0);
    fill(1, 1'b0);
    exp_ids = {0, 1};
    fork
      begin
        send_blocks(0, 0, BLOCKS_PER_FRAME - 1);
        send_blocks(1, 0, BLOCKS_PER_FRAME - 1);
      end
      sink_run(2 * FB, 100, 2 * FB + 400);
    join
    exp_frames += 2;
    checks++;
    if (got_b.size() !== 2 * FB) begin
      errors++;
      $display("FAIL pp_count: got %0d required %0d", got_b.size(), 2 * FB);
    end
    checks++;
    if (stream_bad() !== 0) begin
      errors++;
      $display("FAIL pp_bytes: got %0d bad required 0", stream_bad());
    end
    gap = (got_c.size() == 2 * FB) ? (got_c[FB] - got_c[FB-1] - 1) : 99;
    checks++;
    if (gap > 2) begin
      errors++;
      $display("FAIL pp_gap: got %0d idle cycles required at most 2", gap);
    end
    checks++;
    if (overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL pp_overflow: got %b required 0", overflow_out);
    end
    checks++;
    if (frame_count_out !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL pp_frames: got %0d required %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_overflow();
    for (int f = 0; f < 3; f++) fill(f, 1'b0);
    byte_ready_in = 1'b0;
    send_blocks(0, 0, BLOCKS_PER_FRAME - 1);
    send_blocks(1, 0, BLOCKS_PER_FRAME - 1);
    checks++;
    if (overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: got %b required 0", overflow_out);
    end
    send_blocks(2, 0, 0);
    checks++;
    if (overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL ovf_raise: got %b required 1", overflow_out);
    end
    send_blocks(2, 1, BLOCKS_PER_FRAME - 1);
    exp_ids = {0, 1};
    sink_run(2 * FB, 100, 2 * FB + 400);
    exp_frames += 2;
    repeat (10) step();
    checks++;
    if (got_b.size() !== 2 * FB) begin
      errors++;
      $display("FAIL ovf_count: got %0d required %0d", got_b.size(), 2 * FB);
    end
    checks++;
    if (stream_bad() !== 0) begin
      errors++;
      $display("FAIL ovf_bytes: got %0d bad required 0", stream_bad());
    end
    checks++;
    if ({byte_valid_out, busy_out} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_dropped: got valid,busy=%b required 00", {byte_valid_out, busy_out});
    end
    checks++;
    if (overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", overflow_out);
    end
    checks++;
    if (frame_count_out !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL ovf_frames: got %0d required %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_race();
    apply_reset();
    for (int f = 0; f < 3; f++) fill(f, 1'b0);
    send_blocks(0, 0, BLOCKS_PER_FRAME - 1);
    send_blocks(1, 0, BLOCKS_PER_FRAME - 1);
    repeat (4) step();
    exp_ids = {0, 1, 2};
    // frame 0's last byte is taken on the same edge as frame 2's block 0
    fork
      sink_run(3 * FB, 100, 3 * FB + 600);
      begin
        repeat (FB - 1) step();
        send_blocks(2, 0, BLOCKS_PER_FRAME - 1);
      end
    join
    exp_frames += 3;
    checks++;
    if (overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL race_overflow: got %b required 0", overflow_out);
    end
    checks++;
    if (got_b.size() !== 3 * FB) begin
      errors++;
      $display("FAIL race_count: got %0d required %0d", got_b.size(), 3 * FB);
    end
    checks++;
    if (stream_bad() !== 0) begin
      errors++;
      $display("FAIL race_bytes: got %0d bad required 0", stream_bad());
    end
    checks++;
    if (frame_count_out !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL race_frames: got %0d required %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_async_reset();
    fill(3, 1'b0);
    exp_ids = {3};
    fork
      send_blocks(3, 0, BLOCKS_PER_FRAME - 1);
      sink_run(100, 100, 400);
    join
    checks++;
    if ({byte_valid_out, 7'(got_b.size())} !== {1'b1, 7'd100} || stream_bad() !== 0) begin
      errors++;
      $display("FAIL ar_prefix: got valid=%b count=%0d required valid=1 count=100", byte_valid_out, got_b.size());
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if ({byte_out, byte_valid_out, last_out, frame_count_out, overflow_out, busy_out} !== 28'd0) begin
      errors++;
      $display("FAIL ar_outputs: got %h required 0",
               {byte_out, byte_valid_out, last_out, frame_count_out, overflow_out, busy_out});
    end
    rst_n_in = 1'b1;
    step();
    exp_frames = 0;
    fill(0, 1'b0);
    exp_ids = {0};
    fork
      send_blocks(0, 0, BLOCKS_PER_FRAME - 1);
      sink_run(FB, 100, FB + 300);
    join
    exp_frames++;
    checks++;
    if (got_b.size() !== FB) begin
      errors++;
      $display("FAIL ar_count: got %0d required %0d", got_b.size(), FB);
    end
    checks++;
    if (stream_bad() !== 0) begin
      errors++;
      $display("FAIL ar_bytes: got %0d bad required 0", stream_bad());
    end
    checks++;
    if ({frame_count_out, overflow_out} !== {16'(exp_frames), 1'b0}) begin
      errors++;
      $display("FAIL ar_frames: got %0d ovf=%b required %0d ovf=0", frame_count_out, overflow_out, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_race();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/mont_result_packer.md
# mont_result_packer

Downstream stage of the Montgomery accumulator. It captures each finished 4096-bit result, which arrives as 128 × 32-bit blocks on the accumulator's `valid_out`/`data_out` with no backpressure. It holds the result in a ping-pong buffer and re-emits it as a byte stream with a valid/ready handshake for the UART/host link. A sticky overflow flag is raised if a new result arrives while both banks are still occupied.

## Interface
- `REGISTER_SIZE`, default 32: width of an input block in bits; must be a multiple of 8.
- `BITS_IN_NUM`, default 4096: bits per result; BLOCKS = `BITS_IN_NUM`/`REGISTER_SIZE` = 128.
- `clk_in` input 1: the single clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `valid_in` input 1: one block present this cycle; ignored during reset.
- `data_in` input `REGISTER_SIZE`: result block; least-significant block first.
- `byte_out` output 8: outgoing byte.
- `byte_valid_out` output 1: `byte_out` is valid.
- `byte_ready_in` input 1: sink accepts the byte when high together with `byte_valid_out`.
- `last_out` output 1: current byte is the final byte of a frame.
- `frame_count_out` output 16: number of frames fully sent; wraps at 2^16.
- `overflow_out` output 1: sticky; a frame was dropped.
- `busy_out` output 1: at least one bank is full or being written.

## Operation
**Write side**
- Keeps `wr_bank`, `wr_idx` (0..BLOCKS-1) and a per-frame `drop` flag.
- On each `valid_in`:
  - If `wr_idx`==0: sample `full[wr_bank]`. If the bank is full, set `drop` and set `overflow_out`.
  - If `drop` is clear: write `data_in` to address {`wr_bank`,`wr_idx`}.
  - `wr_idx` increments on every `valid_in`.
  - At `wr_idx`==BLOCKS-1: `wr_idx` wraps to 0. If the frame was not dropped, set `full[wr_bank]` and toggle `wr_bank`. Clear `drop` in either case.
- Dropped frames consume exactly BLOCKS input blocks and write nothing.

**Read side FSM**
- States: `IDLE`, `FETCH`, `SEND`.
- `IDLE`: waits for `full[rd_bank]`, then moves to `FETCH`.
- `FETCH`: issues a read of {`rd_bank`,0}; the data lands one cycle later in `word_q`. Moves to `SEND`.
- `SEND`:
  - Presents byte `byte_sel` of `word_q`, LSB byte first (byte 0 = bits 7:0).
  - On each handshake, `byte_sel` advances.
  - After byte REGISTER_SIZE/8-1, the next block (fetched ahead) is loaded so there is no bubble.
  - `last_out` = (`rd_idx`==BLOCKS-1 && `byte_sel`==last byte).
  - On the last handshake: clear `full[rd_bank]`, toggle `rd_bank`, increment `frame_count_out`. Go to `FETCH` if the other bank is full, otherwise `IDLE`.
- A frame is 512 bytes for the default parameters.

**Boundaries**
- Simultaneous events: if `full[rd_bank]` is cleared in the same cycle the writer samples that bank at `wr_idx`==0, the clear wins and the frame is not dropped.
- `overflow_out` clears only on reset.
- Reset mid-frame:
  - Asynchronous; all pointers, flags and counters return to 0 immediately.
  - Buffer contents become don't-care; the partial frame is discarded.
  - `byte_valid_out` falls in the same instant.

## Timing
- Reset values: `byte_out`=0, `byte_valid_out`=0, `last_out`=0, `frame_count_out`=0, `overflow_out`=0, `busy_out`=0.
- Write: the RAM write and `full` set take effect on the clock edge after the final `valid_in` (cycle W).
- Read start: with the reader in `IDLE`, `byte_valid_out` rises at cycle W+3 (detect at W+1, `FETCH` at W+2, `SEND` at W+3).
- Throughput: with `byte_ready_in` held high, one byte per cycle, continuous across block boundaries. A frame takes 512 consecutive cycles.
- Back-to-back frames: with the next bank already full, at most 2 idle cycles between the last byte of one frame and the first byte of the next.
- Handshake: `byte_out` and `last_out` hold stable while `byte_valid_out`=1 and `byte_ready_in`=0. `byte_valid_out` never drops without a handshake, except on reset.
- Asserting `byte_ready_in` with no valid data has no effect.

## Structure
- Package `mont_pkg`: `BLOCKS_PER_FRAME`, `BYTES_PER_BLOCK`, `rd_state_t` enum {IDLE, FETCH, SEND}, address-width localparams.
- Sub-module `pingpong_buffer`:
  - 2·BLOCKS × `REGISTER_SIZE` simple dual-port RAM.
  - Address {bank, idx}.
  - One write port; one read port with a 1-cycle registered read.
  - Inferable as BRAM.
- All control logic stays in `mont_result_packer`.

## Test plan
- **Single frame:** blocks i = 32'hA5000000+i, sink always ready. Expect `byte_valid_out` at W+3, then 512 consecutive bytes 00,00,00,A5,01,00,00,A5…; `last_out` only on byte 511; `frame_count_out`=1.
- **Backpressure:** `byte_ready_in` random 30% high. Expect identical byte sequence; `byte_out`/`last_out` stable whenever valid && !ready.
- **Ping-pong:** two frames back to back, sink always ready. Expect no drop; ≤2-cycle gap between frames; `frame_count_out`=2; `overflow_out`=0.
- **Overflow:** three frames back to back, `byte_ready_in`=0 throughout. Expect `overflow_out`=1 at the third frame's first block; after the sink is enabled, only frames 1 and 2 are emitted.
- **Race:** release the sink so the final byte of frame 1 is accepted in the same cycle the third frame's block 0 arrives. Expect the third frame accepted and `overflow_out`=0.
- **Async reset mid-SEND (byte 100):** expect all outputs 0 without a clock edge. A subsequent fresh frame is emitted correctly and `frame_count_out`=1.
